// File: rtl/mux4_arb_pkg.sv
// Shared constants and types for the four-lane arbitrated mux.
// Used by mux4_w and mux4_rr_arbiter.
package mux4_arb_pkg;

    localparam int NLANES = 4;
    localparam int SELW   = 2;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    // Pointer starts at the last lane so lane 0 is first in line after reset.
    localparam logic [SELW-1:0] LAST_RST = 2'b11;

endpackage

// File: rtl/mux4_w.sv
// DW-wide 4:1 multiplexer over a packed lane bus.
// Lane i sits at din_i[i*DW +: DW].
module mux4_w
    import mux4_arb_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [NLANES*DW-1:0] din_i,
    input  logic [SELW-1:0]      sel_i,
    output logic [DW-1:0]        dout_o
);

    always_comb begin
        case (sel_i)
            2'd0:    dout_o = din_i[0*DW +: DW];
            2'd1:    dout_o = din_i[1*DW +: DW];
            2'd2:    dout_o = din_i[2*DW +: DW];
            default: dout_o = din_i[3*DW +: DW];
        endcase
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Four-requester arbiter feeding a shared 4:1 mux into a one-entry valid/ready output register.
// Define MUX4_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins); default is round-robin.
module mux4_rr_arbiter
    import mux4_arb_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NLANES-1:0]    req,
    input  logic [NLANES*DW-1:0] din,
    output logic [NLANES-1:0]    gnt,
    output logic [SELW-1:0]      sel,
    output logic                 out_valid,
    output logic [DW-1:0]        out_data,
    input  logic                 out_ready
);

    state_e          state_q;
    logic [DW-1:0]   outData_q;
    logic [SELW-1:0] sel_q;
    logic            capEn;
    logic            anyReq;
    logic [SELW-1:0] winnerIdx;
    logic [DW-1:0]   muxData;

    assign out_valid = (state_q == FULL);
    assign out_data  = outData_q;
    assign sel       = sel_q;

    // A slot opens when the register is empty or its beat leaves this edge.
    assign capEn  = !out_valid || out_ready;
    assign anyReq = |req;
    assign gnt    = (capEn && anyReq) ? (NLANES'(1) << winnerIdx) : '0;

`ifdef MUX4_ARB_FIXED_PRIO_EN
    always_comb begin
        winnerIdx = '0;
        for (int k = NLANES - 1; k >= 0; k--) begin
            if (req[k]) begin
                winnerIdx = SELW'(k);
            end
        end
    end
`else
    logic [SELW-1:0] last_q;
    logic [SELW-1:0] cand;
    logic            found;

    // Scan starts just past the previous winner, wrapping back to it last.
    always_comb begin
        winnerIdx = '0;
        cand      = '0;
        found     = 1'b0;
        for (int k = 1; k <= NLANES; k++) begin
            cand = last_q + SELW'(k);
            if (!found && req[cand]) begin
                winnerIdx = cand;
                found     = 1'b1;
            end
        end
    end
`endif

    mux4_w #(
        .DW (DW)
    ) u_mux (
        .din_i  (din),
        .sel_i  (winnerIdx),
        .dout_o (muxData)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= EMPTY;
            outData_q <= '0;
            sel_q     <= '0;
`ifndef MUX4_ARB_FIXED_PRIO_EN
            last_q    <= LAST_RST;
`endif
        end else if (capEn) begin
            if (anyReq) begin
                state_q   <= FULL;
                outData_q <= muxData;
                sel_q     <= winnerIdx;
`ifndef MUX4_ARB_FIXED_PRIO_EN
                last_q    <= winnerIdx;
`endif
            end else begin
                state_q <= EMPTY;
            end
        end
    end

endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Four-requester arbiter that shares one 4:1 data multiplexer lane between four independent sources and presents the winner on a single registered output with a valid/ready handshake. Each cycle it picks one requesting lane, steers the mux select to that lane, and captures the lane's data into a one-entry output register. It also acknowledges the source with a single-cycle grant. It sits between the four source blocks and the shared downstream consumer, replacing free-running select stimulus with a scheduled `sel`.

## Interface
- `DW`, default 8, data width of each lane and of the output.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous, active-low reset.
- `req`  input  4  per-lane request; `req[i]` high means lane i data is valid.
- `din`  input  4*DW  packed lane data; lane i at `din[i*DW +: DW]`.
- `gnt`  output  4  one-hot grant; `gnt[i]` high for the single cycle in which lane i data is captured.
- `sel`  output  2  index of the lane whose data currently sits in the output register.
- `out_valid`  output  1  output register holds a beat.
- `out_data`  output  DW  captured beat.
- `out_ready`  input  1  consumer accepts the beat at the next rising edge when `out_valid` is high.

## Operation
- Reset values: `out_valid`=0, `out_data`=0, `sel`=2'b00, `gnt`=4'b0000, round-robin pointer `last`=2'b11, so lane 0 wins first.
- Capture enable: `cap_en = !out_valid || out_ready`.
- Winner selection is combinational. Scan lanes `last+1, last+2, last+3, last` (mod 4) and take the first with `req` high. `any_req = |req`.
- `gnt[w] = cap_en && any_req` for the winner w; all other bits are 0. `gnt` is never multi-hot and is 0 whenever `cap_en` is 0.
- On an edge with `cap_en && any_req`:
  - `out_data <= din[w*DW +: DW]`, `sel <= w`, `out_valid <= 1`, `last <= w`.
- On an edge with `cap_en && !any_req`:
  - `out_valid <= 0`.
  - `out_data`, `sel` and `last` hold.
- On an edge with `!cap_en`: all state holds. `req` is ignored and no grant is issued.
- States: EMPTY (`out_valid`=0) and FULL (`out_valid`=1).
  - EMPTY→FULL on any request.
  - FULL→FULL on a handshake with a request pending, or while stalled.
  - FULL→EMPTY on a handshake with no request.
- Source protocol: a source holds `req[i]` and its data stable until it sees `gnt[i]` high at a rising edge. It may then present the next beat immediately.
- Fairness: with all four lanes requesting and `out_ready` held high, grants rotate 0,1,2,3,0,… Each lane waits at most 3 grants.
- Simultaneous drain and refill in the same cycle is required: no bubble.

## Timing
- Request-to-`gnt` latency: 0 cycles. `gnt` is combinational from `req`, `last`, `out_valid` and `out_ready`.
- Request-to-`out_valid` latency: 1 cycle when the register is empty or draining.
- Throughput: 1 beat/cycle with `out_ready` held high.
- `sel` and `out_data` change only on a capture edge and are stable while `out_valid` is high and `out_ready` is low.
- Reset asserted mid-transfer: outputs return to reset values immediately and asynchronously. The held beat is dropped.

## Configuration
- Macro: `MUX4_ARB_FIXED_PRIO_EN`.
- Defined: fixed priority. The lowest requesting index wins, and `last` is not implemented. Lane 3 can starve under continuous lane 0 traffic.
- Undefined (default): round-robin as described in Operation.
- Both builds share the same port list and the same reset values.

## Structure
- Shared package `mux4_arb_pkg`:
  - Lane count constant `NLANES=4`.
  - Select width constant `SELW=2`.
  - FSM state typedef (EMPTY/FULL).
  - Reset value of the pointer.
- Sub-module `mux4_w`: a DW-wide 4:1 mux with packed input, 2-bit select and DW-bit output. It is instantiated once, driven by the combinational winner index, with its output feeding `out_data`.

## Test plan
- Reset release, no requests → `out_valid`=0, `gnt`=0000, `sel`=00, `out_data`=0 for 5 cycles.
- `req`=0100, lane 2 data 8'hA5, `out_ready`=1 → `gnt`=0100 in the same cycle; next cycle `out_valid`=1, `out_data`=A5, `sel`=10.
- `req`=1111 held, `out_ready`=1, lane i data 8'h10+i → `gnt` sequence 0001,0010,0100,1000,0001; `out_data` 10,11,12,13,10 on consecutive cycles, no bubbles.
- FULL with `out_ready`=0 for 4 cycles, `req`=0010 → `gnt`=0000 throughout, `out_data` and `sel` stable. Raise `out_ready` → `gnt`=0010 that cycle and the new beat is captured next edge.
- Assert `rst_n`=0 asynchronously while `out_valid`=1 → `out_valid`=0 and `out_data`=0 before the next clock edge. After release with `req`=1000 → `gnt`=1000, `sel`=11 (pointer restarted).
- Build with `MUX4_ARB_FIXED_PRIO_EN`, `req`=1001 held, `out_ready`=1 → `gnt`=0001 every cycle and lane 3 is never granted.
